// File: rtl/md_scheduler.sv
// Multiply/divide sequencer for the MIPS E stage: owns HI/LO, runs mult/div
// for a fixed latency, serves mfhi/mflo/mthi/mtlo and stalls D behind it.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs_val,
  input  logic [31:0] e_rt_val,
  input  logic        d_is_md,
  output logic        e_start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out,
  output logic        d_stall
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic          state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   rs_q, rt_q;

  logic          is_arith;
  logic          sgn_op, a_neg, b_neg;
  logic [63:0]   m_a, m_b, prod;
  logic [31:0]   dvd, dvs, uq, ur, quo, rem;
  logic [31:0]   res_hi, res_lo;
  logic          res_we;

  assign is_arith = (e_md_op >= OP_MULT) && (e_md_op <= OP_DIVU);
  assign e_start  = e_valid & is_arith & (state == S_IDLE);
  assign busy     = (state == S_BUSY);
  assign d_stall  = d_is_md & (e_start | busy);

  always_comb begin
    md_out = '0;
    if (e_valid && e_md_op == OP_MFHI) md_out = hi;
    if (e_valid && e_md_op == OP_MFLO) md_out = lo;
  end

  // Signed ops run on magnitudes through one unsigned divider, then the
  // signs are restored; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    sgn_op = (op_q == OP_MULT) || (op_q == OP_DIV);
    m_a    = {{32{sgn_op & rs_q[31]}}, rs_q};
    m_b    = {{32{sgn_op & rt_q[31]}}, rt_q};
    prod   = m_a * m_b;
    a_neg  = sgn_op & rs_q[31];
    b_neg  = sgn_op & rt_q[31];
    dvd    = a_neg ? (~rs_q + 32'd1) : rs_q;
    dvs    = b_neg ? (~rt_q + 32'd1) : rt_q;
    uq     = '0;
    ur     = '0;
    if (dvs != 32'd0) begin
      uq = dvd / dvs;
      ur = dvd % dvs;
    end
    quo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem = a_neg ? (~ur + 32'd1) : ur;
    if (op_q == OP_MULT || op_q == OP_MULTU) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_we = 1'b1;
    end else begin
      res_hi = rem;
      res_lo = quo;
      res_we = (rt_q != 32'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (e_start) begin
            op_q  <= e_md_op;
            rs_q  <= e_rs_val;
            rt_q  <= e_rt_val;
            cnt   <= (e_md_op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state <= S_BUSY;
          end else if (e_valid && e_md_op == OP_MTHI) begin
            hi <= e_rs_val;
          end else if (e_valid && e_md_op == OP_MTLO) begin
            lo <= e_rs_val;
          end
        end
        default: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a cycle-level model.
module tb_md_scheduler;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs_val, e_rt_val;
  logic        d_is_md;
  logic        e_start, busy, d_stall;
  logic [31:0] hi, lo, md_out;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
    .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .d_is_md(d_is_md),
    .e_start(e_start), .busy(busy), .hi(hi), .lo(lo),
    .md_out(md_out), .d_stall(d_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: architectural HI/LO plus cycles left on the unit
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_we;
  int          m_left;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    p_we = 1'b1;
    p_hi = '0;
    p_lo = '0;
    sa = a;
    sb = b;
    case (op)
      4'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); {p_hi, p_lo} = sp; end
      4'd2: begin up = {32'b0, a} * {32'b0, b}; {p_hi, p_lo} = up; end
      4'd3: begin
        if (b == 0) p_we = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin p_lo = a; p_hi = 0; end
        else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) p_we = 1'b0;
        else begin p_lo = a / b; p_hi = a % b; end
      end
    endcase
    m_left = (op <= 4'd2) ? MC : DC;
  endtask

  // one clock: drive, check outputs at the falling edge, advance model
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input logic dmd);
    logic        xs, xb, xst;
    logic [31:0] xmd;
    e_valid = v; e_md_op = op; e_rs_val = rs; e_rt_val = rt; d_is_md = dmd;
    xb  = (m_left > 0);
    xs  = v && (op >= 4'd1) && (op <= 4'd4) && !xb;
    xst = dmd && (xs || xb);
    xmd = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    @(negedge clk);
    chk("e_start", 64'(e_start), 64'(xs));
    chk("busy",    64'(busy),    64'(xb));
    chk("d_stall", 64'(d_stall), 64'(xst));
    chk("hi",      64'(hi),      64'(m_hi));
    chk("lo",      64'(lo),      64'(m_lo));
    if (v) chk("md_out", 64'(md_out), 64'(xmd));
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_we) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (xs) begin
      model_start(op, rs, rt);
    end else if (v && op == 4'd7) m_hi = rs;
    else if (v && op == 4'd8) m_lo = rs;
    #1;
  endtask

  task automatic async_reset();
    e_valid = 0; e_md_op = 0; d_is_md = 0;
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    m_hi = '0; m_lo = '0; m_left = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, xhi, xlo;
    int          cyc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    tbl[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    tbl[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, MC};
    tbl[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    tbl[3] = '{4'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    tbl[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC};
    tbl[5] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
    tbl[6] = '{4'd4, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, DC};
    tbl[7] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MC};

    reset = 1'b0; e_valid = 0; e_md_op = 0; e_rs_val = 0; e_rt_val = 0; d_is_md = 0;
    m_hi = '0; m_lo = '0; m_left = 0; p_hi = '0; p_lo = '0; p_we = 0;
    #12;
    chk("reset_busy",  64'(busy),    64'd0);
    chk("reset_hi",    64'(hi),      64'd0);
    chk("reset_lo",    64'(lo),      64'd0);
    chk("reset_start", 64'(e_start), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    repeat (2) step(1, 4'd0, 32'hDEAD_BEEF, 32'h1, 0);

    // directed vectors; div rows keep D stalled so d_stall covers every busy cycle
    foreach (tbl[i]) begin
      logic dmd;
      dmd = (tbl[i].op >= 4'd3);
      step(1, tbl[i].op, tbl[i].rs, tbl[i].rt, dmd);
      cyc = 0;
      for (int k = 0; k < 40 && busy; k++) begin
        cyc++;
        step(0, 4'd0, 32'd0, 32'd0, dmd);
      end
      chk($sformatf("busy_len[%0d]", i), 64'(cyc), 64'(tbl[i].cyc));
      chk($sformatf("vec_hi[%0d]", i), 64'(hi), 64'(tbl[i].xhi));
      chk($sformatf("vec_lo[%0d]", i), 64'(lo), 64'(tbl[i].xlo));
    end

    // mthi then mfhi on the next cycle
    step(1, 4'd7, 32'h1234_5678, 32'd0, 1);
    e_valid = 1; e_md_op = 4'd5;
    #1 chk("mfhi_after_mthi", 64'(md_out), 64'h1234_5678);
    step(1, 4'd5, 32'd0, 32'd0, 1);

    // second mult while busy is dropped; one commit from the first
    step(1, 4'd1, 32'd5, 32'd7, 0);
    step(1, 4'd1, 32'd9, 32'd9, 1);
    step(1, 4'd8, 32'hAAAA_AAAA, 32'd0, 0);
    step(1, 4'd6, 32'd0, 32'd0, 0);
    cyc = 3;
    for (int k = 0; k < 40 && busy; k++) begin
      cyc++;
      step(0, 4'd0, 32'd0, 32'd0, 0);
    end
    chk("drop_busy_len", 64'(cyc), 64'(MC));
    chk("drop_hi", 64'(hi), 64'd0);
    chk("drop_lo", 64'(lo), 64'd35);

    // reset in busy cycle 3 aborts the multiply
    step(1, 4'd7, 32'h5555_0000, 32'd0, 0);
    step(1, 4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    step(0, 4'd0, 32'd0, 32'd0, 0);
    step(0, 4'd0, 32'd0, 32'd0, 0);
    async_reset();
    step(1, 4'd6, 32'd0, 32'd0, 0);
    e_valid = 1; e_md_op = 4'd6;
    #1 chk("mflo_after_abort", 64'(md_out), 64'd0);
    chk("busy_after_abort", 64'(busy), 64'd0);

    // random traffic against the model
    for (int n = 0; n < 700; n++) begin
      logic [31:0] rs, rt;
      int sel;
      rs  = $urandom;
      sel = $urandom_range(0, 3);
      rt  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 9)) : $urandom;
      if ($urandom_range(0, 7) == 0) rs = 32'h8000_0000;
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rs, rt, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
